// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor and the PC-select mux.
// The prediction codes must match the mux's prediction-input encoding.
package branch_predictor_pkg;

  localparam logic [1:0] PRED_NONE = 2'b00;
  localparam logic [1:0] PRED_NT   = 2'b01;
  localparam logic [1:0] PRED_T    = 2'b10;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != CTR_ST)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (!taken_i && (ctr_i != CTR_SNT)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged 2-bit-counter direction predictor with static BTFN
// fallback on a miss, execute-stage training and branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        lookup_imm_sign,
  input  logic        stall,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [1:0]  branch_predict_o,
  output logic        hit_o,
  output logic        mispredict_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_W + IDX_W + 1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         pred_q;
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispredict_cnt_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [1:0]       ctr_sat, ctr_new;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[TAG_HI:TAG_LO];

  // PC bits outside index/tag do not participate in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:TAG_HI+1], lookup_pc[1:0],
                            upd_pc[31:TAG_HI+1], upd_pc[1:0]};

  // Lookup: reads the pre-update table, no bypass from a same-cycle write.
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    branch_predict_o = PRED_NONE;
    hit_o            = 1'b0;
    if (lookup_valid) begin
      hit_o = lk_hit;
      if (lk_hit) begin
        branch_predict_o = ctr_q[lk_idx][1] ? PRED_T : PRED_NT;
      end else begin
        branch_predict_o = lookup_imm_sign ? PRED_T : PRED_NT;
      end
    end
  end

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat (
    .ctr_i   (ctr_q[up_idx]),
    .taken_i (upd_taken),
    .ctr_o   (ctr_sat)
  );

  // A miss allocates the slot in the weak state matching the outcome.
  assign ctr_new = up_hit ? ctr_sat : (upd_taken ? CTR_WT : CTR_WNT);

  assign mispredict_o = upd_valid && (pred_q != PRED_NONE) && (pred_q[1] != upd_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      pred_q           <= PRED_NONE;
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      if (!stall) begin
        pred_q <= branch_predict_o;
      end
      if (upd_valid) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= ctr_new;
        branch_cnt_q    <= branch_cnt_q + 32'd1;
      end
      if (mispredict_o) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  // Tags carry no meaning while the valid bit is clear, so they skip reset.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      tag_q[up_idx] <= up_tag;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_branch_predictor;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_NT   = 2'b01;
  localparam logic [1:0] P_T    = 2'b10;

  localparam int K_PRED = 0, K_HIT = 1, K_MIS = 2, K_BCNT = 3, K_MCNT = 4,
                 K_CTR = 5, K_VALID = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_imm_sign;
  logic        stall;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [1:0]  branch_predict_o;
  logic        hit_o;
  logic        mispredict_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  branch_predictor #(.ENTRIES(32), .TAG_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .lookup_imm_sign  (lookup_imm_sign),
    .stall            (stall),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .branch_predict_o (branch_predict_o),
    .hit_o            (hit_o),
    .mispredict_o     (mispredict_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable at the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_PRED:  act = {30'd0, branch_predict_o};
          K_HIT:   act = {31'd0, hit_o};
          K_MIS:   act = {31'd0, mispredict_o};
          K_BCNT:  act = branch_cnt_o;
          K_MCNT:  act = mispredict_cnt_o;
          K_CTR:   act = {30'd0, dut.ctr_q[e.idx]};
          default: act = dut.valid_q;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string n, input int k, input logic [31:0] v, input int idx = 0);
    exp_t e;
    e.name = n; e.kind = k; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; lookup_valid = 1'b0; lookup_pc = 32'd0; lookup_imm_sign = 1'b0;
    stall = 1'b0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic sign);
    lookup_valid = 1'b1; lookup_pc = pc; lookup_imm_sign = sign;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] up_exp [3];
    logic [1:0] dn_exp [4];
    up_exp = '{2'b10, 2'b11, 2'b11};
    dn_exp = '{2'b10, 2'b01, 2'b00, 2'b00};

    idle(); rst = 1'b1;
    step(); step();

    // Reset state
    idle();
    expect_val("rst_pred", K_PRED, P_NONE);
    expect_val("rst_hit", K_HIT, 0);
    expect_val("rst_mis", K_MIS, 0);
    expect_val("rst_bcnt", K_BCNT, 0);
    expect_val("rst_mcnt", K_MCNT, 0);
    expect_val("rst_valid", K_VALID, 0);
    expect_val("rst_ctr0", K_CTR, 2'b01, 0);
    step();

    // Static fallback on miss
    idle(); lookup(32'h1000, 1'b1);
    expect_val("miss_back_pred", K_PRED, P_T);
    expect_val("miss_back_hit", K_HIT, 0);
    step();
    idle(); lookup(32'h1000, 1'b0);
    expect_val("miss_fwd_pred", K_PRED, P_NT);
    step();
    idle(); lookup_pc = 32'h1000;
    expect_val("no_lookup_pred", K_PRED, P_NONE);
    expect_val("no_lookup_hit", K_HIT, 0);
    step();

    // Saturate up: allocate 10, then 11, stay 11
    for (int i = 0; i < 3; i++) begin
      idle(); update(32'h1000, 1'b1);
      step();
      expect_val($sformatf("sat_up_%0d", i), K_CTR, up_exp[i], 0);
    end
    idle(); lookup(32'h1000, 1'b0);
    expect_val("hit_t_pred", K_PRED, P_T);
    expect_val("hit_t_hit", K_HIT, 1);
    step();

    // Saturate down to 00
    for (int i = 0; i < 4; i++) begin
      idle(); update(32'h1000, 1'b0);
      step();
      expect_val($sformatf("sat_dn_%0d", i), K_CTR, dn_exp[i], 0);
    end
    idle(); lookup(32'h1000, 1'b1);
    expect_val("hit_nt_pred", K_PRED, P_NT);
    expect_val("hit_nt_hit", K_HIT, 1);
    step();

    // Aliasing: 0x1080 shares index 0 with 0x1000
    idle(); update(32'h1000, 1'b1);
    step();
    idle(); update(32'h1080, 1'b0);
    step();
    idle(); lookup(32'h1000, 1'b0);
    expect_val("alias_old_pred", K_PRED, P_NT);
    expect_val("alias_old_hit", K_HIT, 0);
    step();
    idle(); lookup(32'h1080, 1'b1);
    expect_val("alias_new_pred", K_PRED, P_NT);
    expect_val("alias_new_hit", K_HIT, 1);
    step();

    // Same-cycle lookup and update: no bypass
    idle(); update(32'h2000, 1'b0);
    step();
    idle(); lookup(32'h2000, 1'b1); update(32'h2000, 1'b1);
    expect_val("same_cyc_pred", K_PRED, P_NT);
    expect_val("same_cyc_hit", K_HIT, 1);
    step();
    idle(); lookup(32'h2000, 1'b1);
    expect_val("after_upd_pred", K_PRED, P_T);
    expect_val("after_upd_ctr", K_CTR, 2'b10, 0);
    step();

    // Mispredict accounting
    do_reset();
    idle(); lookup(32'h3000, 1'b1);
    expect_val("mp_pred", K_PRED, P_T);
    step();
    idle(); update(32'h3000, 1'b0);
    expect_val("mp_flag", K_MIS, 1);
    step();
    idle();
    expect_val("mp_mcnt", K_MCNT, 1);
    expect_val("mp_bcnt", K_BCNT, 1);
    expect_val("mp_flag_clr", K_MIS, 0);
    step();

    // Same with stall held across the resolution
    do_reset();
    idle(); lookup(32'h3000, 1'b1);
    step();
    idle(); update(32'h3000, 1'b0); stall = 1'b1;
    expect_val("mp_stall_flag", K_MIS, 1);
    step();
    idle(); update(32'h3000, 1'b0); stall = 1'b1;
    expect_val("mp_stall_held", K_MIS, 1);
    expect_val("mp_stall_mcnt", K_MCNT, 1);
    expect_val("mp_stall_bcnt", K_BCNT, 1);
    step();
    idle();
    expect_val("mp_stall_mcnt2", K_MCNT, 2);
    expect_val("mp_stall_bcnt2", K_BCNT, 2);
    step();

    // Update while pred_q is PRED_NONE
    idle(); update(32'h3000, 1'b1);
    expect_val("none_mis", K_MIS, 0);
    step();
    idle();
    expect_val("none_bcnt", K_BCNT, 3);
    expect_val("none_mcnt", K_MCNT, 2);

    // Branch counter wrap
    @(negedge clk);
    #1;
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    update(32'h3000, 1'b1);
    step();
    idle();
    expect_val("wrap_bcnt", K_BCNT, 0);
    step();

    // Reset wins over a same-cycle update
    idle(); rst = 1'b1; update(32'h2000, 1'b1);
    step();
    idle(); lookup(32'h2000, 1'b0);
    expect_val("rst_upd_valid", K_VALID, 0);
    expect_val("rst_upd_pred", K_PRED, P_NT);
    expect_val("rst_upd_hit", K_HIT, 0);
    expect_val("rst_upd_bcnt", K_BCNT, 0);
    expect_val("rst_upd_mcnt", K_MCNT, 0);
    step();

    idle();
    step(); step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
